// File: rtl/xm_bus_ctrl.sv
// xm_bus_ctrl: single-master bus access controller with byte lanes,
// bounded wait for acknowledge, and one-cycle done/fault pulses.
//
// Ports:
//   clk_i, arst_i          clock, synchronous active-high reset
//   req_i, we_i, datSel_i  access request, direction, byte lanes
//   badMem_i               illegal-address flag from the decoder
//   mar_i, omdr_i          word address and write data
//   mem_o                  read data returned to the datapath
//   done_o, fault_o        one-cycle completion / fault pulses
//   busy_o                 transaction in progress
//   bus_*_o, bus_*_i       bus master side (cyc/we/sel/adr/dat/ack)
module xm_bus_ctrl #(
   parameter int WORD    = 16,
   parameter int TIMEOUT = 15
) (
   input  logic            clk_i,
   input  logic            arst_i,
   input  logic            req_i,
   input  logic            we_i,
   input  logic [1:0]      datSel_i,
   input  logic            badMem_i,
   input  logic [WORD-2:0] mar_i,
   input  logic [WORD-1:0] omdr_i,
   output logic [WORD-1:0] mem_o,
   output logic            done_o,
   output logic            fault_o,
   output logic            busy_o,
   output logic            bus_cyc_o,
   output logic            bus_we_o,
   output logic [1:0]      bus_sel_o,
   output logic [WORD-2:0] bus_adr_o,
   output logic [WORD-1:0] bus_dat_o,
   input  logic [WORD-1:0] bus_dat_i,
   input  logic            bus_ack_i
);

   localparam int HALF = WORD / 2;

   // Final ACCESS cycle index; ACCESS lasts at most TIMEOUT cycles.
   localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE,
      S_FAULT
   } state_t;

   state_t          r_state;
   state_t          w_next;

   logic            r_we;
   logic [1:0]      r_sel;
   logic [WORD-2:0] r_adr;
   logic [WORD-1:0] r_dat;
   logic [WORD-1:0] r_mem;
   logic [7:0]      r_cnt;

   logic            w_accept;
   logic            w_reject;
   logic            w_in_acc;
   logic            w_last;
   logic            w_ack;
   logic [WORD-1:0] w_rdat;

   assign w_accept = (r_state == S_IDLE) && req_i;
   assign w_reject = badMem_i || (datSel_i == 2'b00);
   assign w_in_acc = (r_state == S_ACCESS);
   assign w_last   = (r_cnt == LP_LAST);

   // Acknowledge only has meaning while a bus cycle is open.
   assign w_ack    = w_in_acc && bus_ack_i;

   // Byte reads are returned right-justified and zero-extended.
   always_comb begin
      w_rdat = bus_dat_i;
      unique case (r_sel)
         2'b01:   w_rdat = {{HALF{1'b0}}, bus_dat_i[HALF-1:0]};
         2'b10:   w_rdat = {{HALF{1'b0}}, bus_dat_i[WORD-1:HALF]};
         default: w_rdat = bus_dat_i;
      endcase
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (req_i) begin
               if (w_reject) w_next = S_FAULT;
               else          w_next = S_ACCESS;
            end
         end
         S_ACCESS: begin
            // Ack on the final cycle still completes normally.
            if (bus_ack_i)   w_next = S_DONE;
            else if (w_last) w_next = S_FAULT;
         end
         S_DONE:  w_next = S_IDLE;
         S_FAULT: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (arst_i) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Request capture, wait counter and read-data register.
   always_ff @(posedge clk_i) begin
      if (arst_i) begin
         r_we  <= 1'b0;
         r_sel <= 2'b00;
         r_adr <= '0;
         r_dat <= '0;
         r_mem <= '0;
         r_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_we  <= we_i;
            r_sel <= datSel_i;
            r_adr <= mar_i;
            r_dat <= omdr_i;
            r_cnt <= '0;
         end
         if (w_in_acc && !bus_ack_i && !w_last) begin
            r_cnt <= r_cnt + 8'd1;
         end
         if (w_ack && !r_we) begin
            r_mem <= w_rdat;
         end
      end
   end

   // Bus outputs are quiet whenever no cycle is open.
   assign bus_cyc_o = w_in_acc;
   assign bus_we_o  = w_in_acc && r_we;
   assign bus_sel_o = w_in_acc ? r_sel : 2'b00;
   assign bus_adr_o = w_in_acc ? r_adr : '0;
   assign bus_dat_o = w_in_acc ? r_dat : '0;

   assign mem_o   = r_mem;
   assign done_o  = (r_state == S_DONE);
   assign fault_o = (r_state == S_FAULT);
   assign busy_o  = (r_state != S_IDLE);

endmodule

// File: tb/tb_xm_bus_ctrl.sv
// tb_xm_bus_ctrl: directed self-checking bench for xm_bus_ctrl.
// Drives and samples on the falling edge, away from the active edge.
module tb_xm_bus_ctrl;

   logic        clk_i = 1'b0;
   logic        arst_i;
   logic        req_i;
   logic        we_i;
   logic [1:0]  datSel_i;
   logic        badMem_i;
   logic [14:0] mar_i;
   logic [15:0] omdr_i;
   logic [15:0] mem_o;
   logic        done_o;
   logic        fault_o;
   logic        busy_o;
   logic        bus_cyc_o;
   logic        bus_we_o;
   logic [1:0]  bus_sel_o;
   logic [14:0] bus_adr_o;
   logic [15:0] bus_dat_o;
   logic [15:0] bus_dat_i;
   logic        bus_ack_i;

   int n_chk = 0;
   int n_err = 0;

   // Per-transfer observations.
   int          o_cyc;
   int          o_done;
   int          o_fault;
   int          o_done_at;
   int          o_fault_at;
   logic [14:0] s_adr;
   logic [1:0]  s_sel;
   logic        s_we;
   logic [15:0] s_dat;
   logic        s_stable;

   always #5 clk_i = ~clk_i;

   xm_bus_ctrl #(.WORD(16), .TIMEOUT(15)) dut (
      .clk_i     (clk_i),
      .arst_i    (arst_i),
      .req_i     (req_i),
      .we_i      (we_i),
      .datSel_i  (datSel_i),
      .badMem_i  (badMem_i),
      .mar_i     (mar_i),
      .omdr_i    (omdr_i),
      .mem_o     (mem_o),
      .done_o    (done_o),
      .fault_o   (fault_o),
      .busy_o    (busy_o),
      .bus_cyc_o (bus_cyc_o),
      .bus_we_o  (bus_we_o),
      .bus_sel_o (bus_sel_o),
      .bus_adr_o (bus_adr_o),
      .bus_dat_o (bus_dat_o),
      .bus_dat_i (bus_dat_i),
      .bus_ack_i (bus_ack_i)
   );

   task automatic chk(input string tag,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // One request; ack raised on ACCESS cycle ack_wait+1 (-1: never).
   // Runs a fixed 22-cycle window so the timeout case fits.
   task automatic xfer(input logic        we,
                       input logic [1:0]  sel,
                       input logic        bad,
                       input logic [14:0] mar,
                       input logic [15:0] omdr,
                       input int          ack_wait,
                       input logic [15:0] rdat);
      o_cyc      = 0;
      o_done     = 0;
      o_fault    = 0;
      o_done_at  = -1;
      o_fault_at = -1;
      s_stable   = 1'b1;
      @(negedge clk_i);
      req_i     = 1'b1;
      we_i      = we;
      datSel_i  = sel;
      badMem_i  = bad;
      mar_i     = mar;
      omdr_i    = omdr;
      bus_dat_i = rdat;
      for (int k = 1; k <= 22; k++) begin
         @(negedge clk_i);
         if (k == 1) begin
            // Scramble inputs; the controller must use captured copies.
            req_i    = 1'b0;
            we_i     = ~we;
            datSel_i = 2'b00;
            badMem_i = 1'b0;
            mar_i    = 15'h7FFF;
            omdr_i   = 16'hDEAD;
         end
         if (done_o) begin
            o_done++;
            if (o_done_at < 0) o_done_at = k;
         end
         if (fault_o) begin
            o_fault++;
            if (o_fault_at < 0) o_fault_at = k;
         end
         if (bus_cyc_o) begin
            o_cyc++;
            if (o_cyc == 1) begin
               s_adr = bus_adr_o;
               s_sel = bus_sel_o;
               s_we  = bus_we_o;
               s_dat = bus_dat_o;
            end else if (bus_adr_o !== s_adr || bus_sel_o !== s_sel ||
                         bus_we_o !== s_we || bus_dat_o !== s_dat) begin
               s_stable = 1'b0;
            end
         end
         bus_ack_i = bus_cyc_o && (ack_wait >= 0) && (o_cyc == ack_wait + 1);
      end
      bus_ack_i = 1'b0;
   endtask

   initial begin
      arst_i    = 1'b1;
      req_i     = 1'b0;
      we_i      = 1'b0;
      datSel_i  = 2'b00;
      badMem_i  = 1'b0;
      mar_i     = '0;
      omdr_i    = '0;
      bus_dat_i = '0;
      bus_ack_i = 1'b0;
      repeat (2) @(negedge clk_i);

      chk("rst_mem",   32'(mem_o),     32'h0);
      chk("rst_busy",  32'(busy_o),    32'h0);
      chk("rst_cyc",   32'(bus_cyc_o), 32'h0);
      chk("rst_done",  32'(done_o),    32'h0);
      chk("rst_fault", 32'(fault_o),   32'h0);
      arst_i = 1'b0;

      // Ack while idle is ignored.
      @(negedge clk_i);
      bus_ack_i = 1'b1;
      @(negedge clk_i);
      chk("idle_ack_done", 32'(done_o), 32'h0);
      chk("idle_ack_busy", 32'(busy_o), 32'h0);
      bus_ack_i = 1'b0;

      // Word read, two wait cycles.
      xfer(1'b0, 2'b11, 1'b0, 15'h1234, 16'h0000, 2, 16'hBEEF);
      chk("wr_mem",    32'(mem_o),   32'hBEEF);
      chk("wr_cyc",    32'(o_cyc),   32'd3);
      chk("wr_done",   32'(o_done),  32'd1);
      chk("wr_fault",  32'(o_fault), 32'd0);
      chk("wr_adr",    32'(s_adr),   32'h1234);
      chk("wr_sel",    32'(s_sel),   32'h3);
      chk("wr_stable", 32'(s_stable), 32'h1);
      chk("wr_busy",   32'(busy_o),  32'h0);

      // High byte read, immediate ack.
      xfer(1'b0, 2'b10, 1'b0, 15'h0042, 16'h0000, 0, 16'hA55A);
      chk("bh_mem",     32'(mem_o),     32'h00A5);
      chk("bh_cyc",     32'(o_cyc),     32'd1);
      chk("bh_done_at", 32'(o_done_at), 32'd2);
      chk("bh_done",    32'(o_done),    32'd1);

      // Low byte read.
      xfer(1'b0, 2'b01, 1'b0, 15'h0043, 16'h0000, 1, 16'h1234);
      chk("bl_mem", 32'(mem_o), 32'h0034);
      chk("bl_cyc", 32'(o_cyc), 32'd2);

      // Low byte write; read data on the bus must not be captured.
      xfer(1'b1, 2'b01, 1'b0, 15'h0055, 16'h3C3C, 1, 16'hFFFF);
      chk("bw_we",     32'(s_we),     32'h1);
      chk("bw_sel",    32'(s_sel),    32'h1);
      chk("bw_dat",    32'(s_dat),    32'h3C3C);
      chk("bw_adr",    32'(s_adr),    32'h0055);
      chk("bw_stable", 32'(s_stable), 32'h1);
      chk("bw_mem",    32'(mem_o),    32'h0034);
      chk("bw_done",   32'(o_done),   32'd1);

      // No ack at all: timeout.
      xfer(1'b0, 2'b11, 1'b0, 15'h0100, 16'h0000, -1, 16'h9999);
      chk("to_cyc",   32'(o_cyc),   32'd15);
      chk("to_fault", 32'(o_fault), 32'd1);
      chk("to_done",  32'(o_done),  32'd0);
      chk("to_mem",   32'(mem_o),   32'h0034);
      chk("to_busy",  32'(busy_o),  32'h0);

      // Ack on the 15th ACCESS cycle beats the timeout.
      xfer(1'b0, 2'b11, 1'b0, 15'h0101, 16'h0000, 14, 16'h1357);
      chk("ta_cyc",   32'(o_cyc),   32'd15);
      chk("ta_done",  32'(o_done),  32'd1);
      chk("ta_fault", 32'(o_fault), 32'd0);
      chk("ta_mem",   32'(mem_o),   32'h1357);

      // Illegal address.
      xfer(1'b0, 2'b11, 1'b1, 15'h0200, 16'h0000, 0, 16'h1111);
      chk("bad_cyc",   32'(o_cyc),      32'd0);
      chk("bad_fault", 32'(o_fault),    32'd1);
      chk("bad_at",    32'(o_fault_at), 32'd1);
      chk("bad_mem",   32'(mem_o),      32'h1357);

      // Invalid byte lanes.
      xfer(1'b1, 2'b00, 1'b0, 15'h0201, 16'h2222, 0, 16'h2222);
      chk("sel0_cyc",   32'(o_cyc),      32'd0);
      chk("sel0_fault", 32'(o_fault),    32'd1);
      chk("sel0_at",    32'(o_fault_at), 32'd1);
      chk("sel0_done",  32'(o_done),     32'd0);

      // Reset in the middle of ACCESS, colliding with an ack.
      @(negedge clk_i);
      req_i     = 1'b1;
      we_i      = 1'b0;
      datSel_i  = 2'b11;
      badMem_i  = 1'b0;
      mar_i     = 15'h0300;
      bus_dat_i = 16'h7777;
      @(negedge clk_i);
      req_i = 1'b0;
      chk("mr_cyc_pre", 32'(bus_cyc_o), 32'h1);
      @(negedge clk_i);
      arst_i    = 1'b1;
      bus_ack_i = 1'b1;
      @(negedge clk_i);
      chk("mr_cyc",  32'(bus_cyc_o), 32'h0);
      chk("mr_busy", 32'(busy_o),    32'h0);
      chk("mr_done", 32'(done_o),    32'h0);
      chk("mr_mem",  32'(mem_o),     32'h0);
      arst_i = 1'b0;
      @(negedge clk_i);
      chk("mr_done2", 32'(done_o),    32'h0);
      chk("mr_cyc2",  32'(bus_cyc_o), 32'h0);
      bus_ack_i = 1'b0;

      // Normal transfer after the reset.
      xfer(1'b0, 2'b11, 1'b0, 15'h0301, 16'h0000, 1, 16'h2468);
      chk("ar_mem",  32'(mem_o),  32'h2468);
      chk("ar_done", 32'(o_done), 32'd1);
      chk("ar_cyc",  32'(o_cyc),  32'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
